// File: rtl/hazard_controller_if.sv
// Decode-stage hazard controller bus.
// master: pipeline side, drives ID/EX/MEM hazard sources and observes controls.
// slave : hazard_controller, consumes hazard sources and drives enables/counters.
interface hazard_controller_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 32
);
    logic [REG_ADDR_W-1:0] rs1ID_i;
    logic [REG_ADDR_W-1:0] rs2ID_i;
    logic                  useRs1_i;
    logic                  useRs2_i;
    logic                  Branch_i;
    logic                  Ret_i;
    logic [1:0]            PCsrc_i;
    logic [REG_ADDR_W-1:0] rdEX_i;
    logic                  RegWriteEX_i;
    logic                  MemReadEX_i;
    logic [REG_ADDR_W-1:0] rdMEM_i;
    logic                  MemReadMEM_i;
    logic                  memStall_i;
    logic                  pcWrite_o;
    logic                  ifidWrite_o;
    logic                  ifidFlush_o;
    logic                  controlZeroSel_o;
    logic                  pipeWrite_o;
    logic [PERF_W-1:0]     stallCount_o;
    logic [PERF_W-1:0]     flushCount_o;

    modport master (
        output rs1ID_i, rs2ID_i, useRs1_i, useRs2_i, Branch_i, Ret_i, PCsrc_i,
               rdEX_i, RegWriteEX_i, MemReadEX_i, rdMEM_i, MemReadMEM_i, memStall_i,
        input  pcWrite_o, ifidWrite_o, ifidFlush_o, controlZeroSel_o, pipeWrite_o,
               stallCount_o, flushCount_o
    );

    modport slave (
        input  rs1ID_i, rs2ID_i, useRs1_i, useRs2_i, Branch_i, Ret_i, PCsrc_i,
               rdEX_i, RegWriteEX_i, MemReadEX_i, rdMEM_i, MemReadMEM_i, memStall_i,
        output pcWrite_o, ifidWrite_o, ifidFlush_o, controlZeroSel_o, pipeWrite_o,
               stallCount_o, flushCount_o
    );
endinterface

// File: rtl/hazard_controller.sv
// Decode-stage sequencing controller: load-use / branch-operand stall insertion,
// IF/ID flush on taken redirects, full freeze on data-memory busy, perf counters.
// Ports: clk_i, rst_ni (async active-low), bus (hazard_controller_if.slave).
// Control outputs are combinational from state and inputs; counters are registered.
module hazard_controller #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    hazard_controller_if.slave   bus
);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       m_ex, m_mem, cmp;
    logic [1:0] need;
    logic       pc_write, ifid_write, ifid_flush, ctrl_zero, pipe_write;

    // Hazard detection: x0 never creates a dependency.
    always_comb begin
        m_ex  = (bus.rdEX_i != REG_ZERO) &&
                (((bus.rdEX_i == bus.rs1ID_i) && bus.useRs1_i) ||
                 ((bus.rdEX_i == bus.rs2ID_i) && bus.useRs2_i));
        m_mem = (bus.rdMEM_i != REG_ZERO) &&
                (((bus.rdMEM_i == bus.rs1ID_i) && bus.useRs1_i) ||
                 ((bus.rdMEM_i == bus.rs2ID_i) && bus.useRs2_i));
        cmp   = bus.Branch_i || bus.Ret_i;
        need  = 2'd0;
        if (cmp && bus.MemReadEX_i && m_ex)             need = 2'd2;
        else if (bus.MemReadEX_i && m_ex)               need = 2'd1;
        else if (cmp && bus.RegWriteEX_i && m_ex)       need = 2'd1;
        else if (cmp && bus.MemReadMEM_i && m_mem)      need = 2'd1;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_RUN;
        else         state_q <= state_d;
    end

    // Next state: freeze holds everything; HOLD always returns to RUN.
    always_comb begin
        state_d = state_q;
        if (!bus.memStall_i) begin
            if (state_q == ST_HOLD)  state_d = ST_RUN;
            else if (need == 2'd2)   state_d = ST_HOLD;
        end
    end

    // Output decode; reset forces the free-running values.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        pipe_write = 1'b1;
        ifid_flush = 1'b0;
        ctrl_zero  = 1'b0;
        if (rst_ni) begin
            if (bus.memStall_i) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_write = 1'b0;
            end else if ((state_q == ST_HOLD) || (need != 2'd0)) begin
                // Stall wins over redirect; the branch re-resolves later.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ctrl_zero  = 1'b1;
            end else if (bus.PCsrc_i != 2'b00) begin
                ifid_flush = 1'b1;
            end
        end
    end

    // Wrapping performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q + PERF_W'(ctrl_zero);
        flush_cnt_d = flush_cnt_q + PERF_W'(ifid_flush);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pcWrite_o        = pc_write;
    assign bus.ifidWrite_o      = ifid_write;
    assign bus.ifidFlush_o      = ifid_flush;
    assign bus.controlZeroSel_o = ctrl_zero;
    assign bus.pipeWrite_o      = pipe_write;
    assign bus.stallCount_o     = stall_cnt_q;
    assign bus.flushCount_o     = flush_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a driver applies one stimulus per cycle
// and queues the reference model's expected outputs; a negedge monitor compares.
module tb_hazard_controller;
    localparam int unsigned RW = 5;
    localparam int unsigned PW = 4;
    localparam int CNT_MOD = 16;

    typedef struct packed {
        bit          rst_n;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          use1;
        bit          use2;
        bit          br;
        bit          ret;
        logic [1:0]  pcsrc;
        logic [4:0]  rdex;
        bit          regwr_ex;
        bit          memrd_ex;
        logic [4:0]  rdmem;
        bit          memrd_mem;
        bit          memstall;
    } stim_t;

    typedef struct {
        int pc, ifid, flush, zero, pipe, scnt, fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_controller_if #(.REG_ADDR_W(RW), .PERF_W(PW)) bus ();

    hazard_controller #(.REG_ADDR_W(RW), .PERF_W(PW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state: extra bubble cycles still owed, counters.
    int m_pending = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Bubbles a decode instruction needs, straight from the dependency rules.
    function automatic int need_of(input stim_t s);
        bit dep_ex, dep_mem, resolves;
        dep_ex  = (s.rdex != 0) && ((s.use1 && s.rdex == s.rs1) || (s.use2 && s.rdex == s.rs2));
        dep_mem = (s.rdmem != 0) && ((s.use1 && s.rdmem == s.rs1) || (s.use2 && s.rdmem == s.rs2));
        resolves = s.br || s.ret;
        if (s.memrd_ex && dep_ex) return resolves ? 2 : 1;
        if (resolves && s.regwr_ex && dep_ex) return 1;
        if (resolves && s.memrd_mem && dep_mem) return 1;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        rst_n            = s.rst_n;
        bus.rs1ID_i      = s.rs1;
        bus.rs2ID_i      = s.rs2;
        bus.useRs1_i     = s.use1;
        bus.useRs2_i     = s.use2;
        bus.Branch_i     = s.br;
        bus.Ret_i        = s.ret;
        bus.PCsrc_i      = s.pcsrc;
        bus.rdEX_i       = s.rdex;
        bus.RegWriteEX_i = s.regwr_ex;
        bus.MemReadEX_i  = s.memrd_ex;
        bus.rdMEM_i      = s.rdmem;
        bus.MemReadMEM_i = s.memrd_mem;
        bus.memStall_i   = s.memstall;
        e = '{pc: 1, ifid: 1, flush: 0, zero: 0, pipe: 1, scnt: 0, fcnt: 0};
        if (!s.rst_n) begin
            m_pending = 0;
            m_stall   = 0;
            m_flush   = 0;
        end else if (s.memstall) begin
            e.pc = 0; e.ifid = 0; e.pipe = 0;
        end else begin
            n = (m_pending > 0) ? 1 : need_of(s);
            if (n > 0) begin
                e.pc = 0; e.ifid = 0; e.zero = 1;
                if (m_pending > 0) m_pending--;
                else               m_pending = n - 1;
            end else if (s.pcsrc != 0) begin
                e.flush = 1;
            end
        end
        e.scnt = m_stall;
        e.fcnt = m_flush;
        m_stall = (m_stall + e.zero) % CNT_MOD;
        m_flush = (m_flush + e.flush) % CNT_MOD;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pcWrite",        int'(bus.pcWrite_o),        e.pc);
            check("ifidWrite",      int'(bus.ifidWrite_o),      e.ifid);
            check("ifidFlush",      int'(bus.ifidFlush_o),      e.flush);
            check("controlZeroSel", int'(bus.controlZeroSel_o), e.zero);
            check("pipeWrite",      int'(bus.pipeWrite_o),      e.pipe);
            check("stallCount",     int'(bus.stallCount_o),     e.scnt);
            check("flushCount",     int'(bus.flushCount_o),     e.fcnt);
        end
    end

    initial begin
        stim_t s, ld;
        rst_n = 1'b0;
        bus.rs1ID_i = '0; bus.rs2ID_i = '0; bus.useRs1_i = 0; bus.useRs2_i = 0;
        bus.Branch_i = 0; bus.Ret_i = 0; bus.PCsrc_i = '0; bus.rdEX_i = '0;
        bus.RegWriteEX_i = 0; bus.MemReadEX_i = 0; bus.rdMEM_i = '0;
        bus.MemReadMEM_i = 0; bus.memStall_i = 0;

        // Reset with hazard-looking inputs: outputs must stay at run values.
        s = idle(); s.rst_n = 0; s.memstall = 1; s.pcsrc = 2'b11;
        step(s); step(s);
        step(idle());

        // Load in EX writing x5.
        ld = idle(); ld.rdex = 5; ld.memrd_ex = 1; ld.regwr_ex = 1;
        s = ld; s.rs1 = 5; s.use1 = 1;
        step(s); step(idle());
        // Load feeding a branch: two bubbles, HOLD ignores dropped inputs.
        s = ld; s.rs2 = 5; s.use2 = 1; s.br = 1;
        step(s); step(idle()); step(idle());
        // ALU result feeding a return, then rd = x0.
        s = idle(); s.rdex = 7; s.regwr_ex = 1; s.ret = 1; s.rs1 = 7; s.use1 = 1;
        step(s);
        s.rdex = 0;
        step(s);
        // Load in MEM feeding a branch.
        s = idle(); s.rdmem = 9; s.memrd_mem = 1; s.br = 1; s.rs2 = 9; s.use2 = 1;
        step(s);
        // Redirect alone, then redirect blocked by a stall.
        s = idle(); s.pcsrc = 2'b01;
        step(s);
        s = ld; s.rs1 = 5; s.use1 = 1; s.pcsrc = 2'b01;
        step(s);
        step(idle());
        // Freeze for three cycles while in HOLD.
        s = ld; s.rs1 = 5; s.use1 = 1; s.br = 1;
        step(s);
        s = idle(); s.memstall = 1; s.pcsrc = 2'b10;
        step(s); step(s); step(s);
        step(idle()); step(idle());
        // Drive the stall counter round its wrap.
        s = ld; s.rs1 = 5; s.use1 = 1;
        for (int i = 0; i < 18; i++) step(s);
        // Reset asserted mid-HOLD.
        s = ld; s.rs1 = 5; s.use1 = 1; s.ret = 1;
        step(s);
        s = idle(); s.rst_n = 0;
        step(s);
        step(idle()); step(idle());

        // Randomized traffic over a small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n     = ($urandom_range(0, 199) != 0);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.use1      = 1'($urandom);
            s.use2      = 1'($urandom);
            s.br        = ($urandom_range(0, 2) == 0);
            s.ret       = ($urandom_range(0, 5) == 0);
            s.pcsrc     = 2'($urandom);
            s.rdex      = 5'($urandom_range(0, 3));
            s.regwr_ex  = 1'($urandom);
            s.memrd_ex  = ($urandom_range(0, 2) == 0);
            s.rdmem     = 5'($urandom_range(0, 3));
            s.memrd_mem = ($urandom_range(0, 2) == 0);
            s.memstall  = ($urandom_range(0, 5) == 0);
            step(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the decode stage, where branches, jumps and returns resolve. It detects load-use and branch-operand hazards and inserts the required bubbles through the decode control-reset mux. It flushes IF/ID on taken redirects, freezes the whole pipeline while data memory is busy, and keeps stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register address width
PERF_W, 32, width of the performance counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rs1ID_i  in  REG_ADDR_W  rs1 of the instruction in ID
rs2ID_i  in  REG_ADDR_W  rs2 of the instruction in ID
useRs1_i  in  1  ID instruction reads rs1
useRs2_i  in  1  ID instruction reads rs2
Branch_i  in  1  ID instruction is a conditional branch
Ret_i  in  1  ID instruction is a register-indirect jump
PCsrc_i  in  2  ID redirect select; nonzero means taken redirect
rdEX_i  in  REG_ADDR_W  destination register in EX
RegWriteEX_i  in  1  EX writes the register file
MemReadEX_i  in  1  EX is a load
rdMEM_i  in  REG_ADDR_W  destination register in MEM
MemReadMEM_i  in  1  MEM is a load
memStall_i  in  1  data memory busy
pcWrite_o  out  1  PC update enable
ifidWrite_o  out  1  IF/ID register enable
ifidFlush_o  out  1  load NOP into IF/ID
controlZeroSel_o  out  1  zero ID control signals (bubble into ID/EX)
pipeWrite_o  out  1  ID/EX, EX/MEM and MEM/WB enable
stallCount_o  out  PERF_W  bubble cycles inserted
flushCount_o  out  PERF_W  IF/ID flushes issued

Behaviour:
- Match terms (rd==0 never matches):
  - mEX1 = rdEX==rs1ID && useRs1. Likewise mEX2, mMEM1, mMEM2.
  - mEX = mEX1||mEX2; mMEM = mMEM1||mMEM2.
  - cmp = Branch_i||Ret_i.
- Hazard need N (cycles):
  - N=2 if cmp && MemReadEX && mEX.
  - Else N=1 if MemReadEX && mEX (load-use).
  - Else N=1 if cmp && RegWriteEX && mEX.
  - Else N=1 if cmp && MemReadMEM && mMEM.
  - Else N=0.
- FSM states: RUN, HOLD (one extra stall cycle). Register stCnt is 1 bit.
- Outputs by priority:
  1. memStall_i=1 (any state): FREEZE. pcWrite=0, ifidWrite=0, pipeWrite=0, controlZeroSel=0, ifidFlush=0. State and counters hold. No bubble is inserted.
  2. State HOLD: STALL. pcWrite=0, ifidWrite=0, controlZeroSel=1, pipeWrite=1, ifidFlush=0. Next state is RUN. Hazard inputs are ignored.
  3. RUN with N>0: STALL outputs as above. N=2 moves to HOLD; N=1 stays in RUN.
  4. RUN with N=0 and PCsrc_i!=0: pcWrite=1, ifidWrite=1, ifidFlush=1, controlZeroSel=0, pipeWrite=1.
  5. Otherwise: pcWrite=1, ifidWrite=1, pipeWrite=1, all others 0.
- All control outputs are combinational from state and inputs, so there is zero latency. They take effect at the next rising clk_i.
- A redirect is never flushed while a stall is active. The branch re-resolves once its operands are ready.
- stallCount_o increments by 1 on each clock edge where controlZeroSel_o=1. flushCount_o increments on each edge where ifidFlush_o=1. Both wrap from 2^PERF_W-1 to 0 and never saturate.
- Reset (async, rst_ni=0):
  - State goes to RUN and both counters to 0, immediately.
  - While rst_ni=0: pcWrite_o=1, ifidWrite_o=1, pipeWrite_o=1, ifidFlush_o=0, controlZeroSel_o=0, regardless of other inputs.
  - Reset asserted while in HOLD abandons the pending stall cycle.
  - Release is synchronised to the first clk_i edge at which rst_ni=1.

Test Plan:
1. rdEX=5, MemReadEX=1, RegWriteEX=1; ID uses rs1=5, Branch=0 -> exactly 1 cycle with pcWrite=0, ifidWrite=0, controlZeroSel=1; stallCount 0->1.
2. Same load in EX with Branch=1, rs2ID=5, useRs2=1 -> 2 consecutive stall cycles (RUN->HOLD->RUN); the HOLD cycle ignores inputs dropped to 0; stallCount=2.
3. ALU op in EX writing x7 (RegWriteEX=1, MemReadEX=0), Ret=1, rs1ID=7 -> 1 stall cycle; rdEX=0 with the same inputs -> no stall.
4. No hazard, PCsrc=2'b01 -> ifidFlush=1 for that cycle with pcWrite=1; flushCount 0->1. PCsrc=01 together with an N=1 hazard -> stall, no flush.
5. memStall_i=1 for 3 cycles during HOLD -> all enables 0 for 3 cycles, state stays HOLD; the stall cycle completes after memStall drops; counters unchanged during the freeze.
6. Preload stallCount to all-ones via repeated stalls (PERF_W=4: 15 stalls) then 1 more -> wraps to 0; rst_ni pulsed low mid-HOLD -> outputs go to run values immediately and counters to 0.
